adc_sample_capture: RTL and testbench
=====================================

ADC_SAMPLE_CAPTURE -- requirements
Module: adc_sample_capture

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the ADC sample width in bits.
REQ-002 Parameter NUM_CH, default 4, SHALL set the number of channels per frame (1..8).
REQ-003 Parameter TIMEOUT_CYC, default 1024, SHALL set the frame abort limit in CLK cycles.
REQ-004 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 RST  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 start_i  in  1  SHALL be the frame start pulse (same strobe as the address sequencer init).
REQ-007 add_i  in  3  SHALL be the channel address currently driven to the ADC mux by the address sequencer.
REQ-008 oe_i  in  1  SHALL be the ADC output-enable strobe; data_i is valid while high.
REQ-009 data_i  in  DATA_W  SHALL be the ADC conversion result.
REQ-010 ch_data_o  out  NUM_CH*DATA_W  SHALL hold the last complete frame; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 frame_valid_o  out  1  SHALL pulse one cycle when ch_data_o is updated.
REQ-012 busy_o  out  1  SHALL be high while a frame is being captured.
REQ-013 timeout_o  out  1  SHALL pulse one cycle when a frame is aborted.
REQ-014 addr_err_o  out  1  SHALL be a sticky flag for an address >= NUM_CH during capture.

Function
REQ-015 The FSM SHALL have states IDLE, CAPTURE and DONE.
REQ-016 IDLE -> CAPTURE on start_i=1: clear the written mask and timeout counter, clear addr_err_o, and set busy_o=1 in the next cycle.
REQ-017 In CAPTURE, a capture event SHALL be oe_i=1 with oe_i=0 in the previous cycle (registered rising edge).
REQ-018 On a capture event with add_i<NUM_CH, data_i SHALL be written to shadow slot add_i and mask bit add_i SHALL be set, both in the same cycle.
REQ-019 A repeated address within a frame SHALL overwrite its shadow slot without changing the mask.
REQ-020 A capture event with add_i>=NUM_CH SHALL leave the shadow slots unchanged and set addr_err_o.
REQ-021 CAPTURE -> DONE in the cycle after the mask becomes all ones.
REQ-022 In DONE, shadow SHALL copy to ch_data_o and frame_valid_o=1 for exactly one cycle; busy_o=0; the next state SHALL be IDLE.
REQ-023 In CAPTURE, the timeout counter SHALL increment every cycle.
REQ-024 When the timeout counter reaches TIMEOUT_CYC-1 without completion: timeout_o=1 for one cycle, return to IDLE, ch_data_o unchanged.
REQ-025 start_i in CAPTURE or DONE SHALL be ignored.
REQ-026 oe_i edges in IDLE or DONE SHALL be ignored.
REQ-027 start_i and an oe_i edge in the same IDLE cycle SHALL start the frame and SHALL NOT capture that edge.
REQ-028 A capture event on the cycle timeout fires SHALL be discarded; timeout takes precedence.

Reset
REQ-029 RST=1 SHALL force IDLE and clear ch_data_o, the shadow slots, the mask, the timeout counter, the oe_i edge register, busy_o, frame_valid_o, timeout_o and addr_err_o to 0.
REQ-030 RST during CAPTURE SHALL abandon the frame with no frame_valid_o or timeout_o pulse; RST overrides all other inputs.

Configuration
REQ-031 Macro ADC_CAPTURE_AVG_EN, when defined, SHALL compute each DONE update as ch = (ch_old + shadow) >> 1 using a DATA_W+1-bit sum and floor rounding.
REQ-032 With ADC_CAPTURE_AVG_EN defined, the first DONE after reset SHALL load shadow directly, tracked by a primed flag cleared by RST.
REQ-033 Without ADC_CAPTURE_AVG_EN, DONE SHALL copy shadow directly with no averaging hardware.

Verification
REQ-034 Start, then oe edges at add 0,1,2,3 with data 0x11,0x22,0x33,0x44 -> one frame_valid pulse; ch_data_o=0x44332211; busy_o low.
REQ-035 Frame with add 1 given twice (0xAA then 0xBB), then 0,2,3 -> slot1=0xBB; exactly one frame_valid pulse.
REQ-036 Start, only 3 channels captured, TIMEOUT_CYC=16 -> timeout_o pulse at cycle 16 of CAPTURE; ch_data_o unchanged; state IDLE.
REQ-037 Edge with add_i=5 mid-frame -> addr_err_o=1; shadow unchanged; addr_err_o cleared by the next start_i.
REQ-038 RST after 2 captures, then a full frame -> only post-reset data appears; no pulse from the aborted frame.
REQ-039 AVG_EN: frame1 ch0=0x10, frame2 ch0=0x21 -> ch0 reads 0x10, then 0x18.

Source files
------------

// File: rtl/adc_sample_capture.sv
// ADC frame capture: collects one sample per channel address into shadow slots
// and publishes a complete frame. Optional averaging via ADC_CAPTURE_AVG_EN.
module adc_sample_capture #(
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start_i,
  input  logic [2:0]               add_i,
  input  logic                     oe_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [NUM_CH*DATA_W-1:0] ch_data_o,
  output logic                     frame_valid_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic                     addr_err_o
);

  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t                         state;
  logic [NUM_CH-1:0][DATA_W-1:0]  shadow;
  logic [NUM_CH-1:0][DATA_W-1:0]  ch_q;
  logic [NUM_CH-1:0][DATA_W-1:0]  frame_next;
  logic [NUM_CH-1:0]              mask;
  logic [CW-1:0]                  tcnt;
  logic                           oe_q;
  logic                           cap_evt;
  logic                           addr_ok;
  logic                           mask_full;
  logic                           tmo_hit;

  assign cap_evt   = oe_i & ~oe_q;
  assign addr_ok   = {29'd0, add_i} < 32'(NUM_CH);
  assign mask_full = &mask;
  assign tmo_hit   = (tcnt == CW'(TIMEOUT_CYC - 1));
  assign ch_data_o = ch_q;

`ifdef ADC_CAPTURE_AVG_EN
  logic              primed;
  logic [DATA_W:0]   sum;

  // First frame after reset loads directly; later frames average with floor.
  always_comb begin
    frame_next = shadow;
    sum        = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ch_q[k]} + {1'b0, shadow[k]};
      if (primed) frame_next[k] = sum[DATA_W:1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                               primed <= 1'b0;
    else if (state == CAPTURE && mask_full) primed <= 1'b1;
  end
`else
  assign frame_next = shadow;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      shadow        <= '0;
      ch_q          <= '0;
      mask          <= '0;
      tcnt          <= '0;
      oe_q          <= 1'b0;
      busy_o        <= 1'b0;
      frame_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
      addr_err_o    <= 1'b0;
    end else begin
      oe_q          <= oe_i;
      frame_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= CAPTURE;
            mask       <= '0;
            tcnt       <= '0;
            addr_err_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        CAPTURE: begin
          tcnt <= tcnt + 1'b1;
          // Completion wins over timeout; timeout wins over a same-cycle capture.
          if (mask_full) begin
            state         <= DONE;
            ch_q          <= frame_next;
            frame_valid_o <= 1'b1;
            busy_o        <= 1'b0;
          end else if (tmo_hit) begin
            state     <= IDLE;
            timeout_o <= 1'b1;
            busy_o    <= 1'b0;
          end else if (cap_evt) begin
            if (addr_ok) begin
              shadow[add_i[AW-1:0]] <= data_i;
              mask[add_i[AW-1:0]]   <= 1'b1;
            end else begin
              addr_err_o <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_capture.sv
// Randomized self-checking bench for adc_sample_capture against a frame-level model.
module tb_adc_sample_capture;

  localparam int DATA_W      = 8;
  localparam int NUM_CH      = 4;
  localparam int TIMEOUT_CYC = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start_i;
  logic [2:0]               add_i;
  logic                     oe_i;
  logic [DATA_W-1:0]        data_i;
  logic [NUM_CH*DATA_W-1:0] ch_data_o;
  logic                     frame_valid_o;
  logic                     busy_o;
  logic                     timeout_o;
  logic                     addr_err_o;

  always #5 clk = ~clk;

  adc_sample_capture #(
    .DATA_W     (DATA_W),
    .NUM_CH     (NUM_CH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .start_i      (start_i),
    .add_i        (add_i),
    .oe_i         (oe_i),
    .data_i       (data_i),
    .ch_data_o    (ch_data_o),
    .frame_valid_o(frame_valid_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .addr_err_o   (addr_err_o)
  );

  int checks = 0;
  int errors = 0;

  // Pulse counters and busy-run length observed at each negedge.
  int fv_cnt = 0, to_cnt = 0, run = 0, to_run = 0;
  always @(negedge clk) begin
    if (frame_valid_o) fv_cnt++;
    if (timeout_o) to_cnt++;
    if (busy_o) run++;
    else begin
      if (timeout_o) to_run = run;
      run = 0;
    end
  end

  // Frame-level reference model.
  int  m_sh [NUM_CH];
  int  m_ch [NUM_CH];
  bit  m_written [NUM_CH];
  bit  m_primed;
  bit  m_err;
  int  fv0, to0;

  function automatic logic [NUM_CH*DATA_W-1:0] m_packed();
    logic [NUM_CH*DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = DATA_W'(m_ch[k]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start_i = 1'b0; oe_i = 1'b0; add_i = '0; data_i = '0;
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin m_ch[k] = 0; m_sh[k] = 0; m_written[k] = 0; end
    m_primed = 0; m_err = 0;
  endtask

  task automatic do_start();
    fv0 = fv_cnt; to0 = to_cnt;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    for (int k = 0; k < NUM_CH; k++) m_written[k] = 0;
    m_err = 0;
  endtask

  task automatic do_edge(input int a, input int d, input bit with_start);
    add_i = 3'(a); data_i = DATA_W'(d); oe_i = 1'b1; start_i = with_start;
    cyc();
    oe_i = 1'b0; start_i = 1'b0;
    cyc();
    if (a < NUM_CH) begin m_sh[a] = d; m_written[a] = 1; end
    else m_err = 1;
  endtask

  task automatic expect_frame(input string tag);
    int n = 0;
    while (!frame_valid_o && n < 10) begin cyc(); n++; end
    chk({tag, "_fv"}, 64'(frame_valid_o), 64'd1);
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef ADC_CAPTURE_AVG_EN
      m_ch[k] = m_primed ? (m_ch[k] + m_sh[k]) / 2 : m_sh[k];
`else
      m_ch[k] = m_sh[k];
`endif
    end
    m_primed = 1;
    chk({tag, "_data"}, 64'(ch_data_o), 64'(m_packed()));
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    cyc(); cyc(); cyc();
    chk({tag, "_pulses"}, 64'(fv_cnt - fv0), 64'd1);
  endtask

  initial begin
    int  ord [NUM_CH];
    int  n, tmp, j, kind;

    do_reset();
    chk("rst_data",  64'(ch_data_o),     64'd0);
    chk("rst_busy",  64'(busy_o),        64'd0);
    chk("rst_fv",    64'(frame_valid_o), 64'd0);
    chk("rst_to",    64'(timeout_o),     64'd0);
    chk("rst_err",   64'(addr_err_o),    64'd0);

`ifdef ADC_CAPTURE_AVG_EN
    do_start();
    do_edge(0, 'h10, 0); do_edge(1, 1, 0); do_edge(2, 2, 0); do_edge(3, 3, 0);
    expect_frame("avg1");
    chk("avg1_ch0", 64'(ch_data_o[7:0]), 64'h10);
    do_start();
    do_edge(0, 'h21, 0); do_edge(1, 1, 0); do_edge(2, 2, 0); do_edge(3, 3, 0);
    expect_frame("avg2");
    chk("avg2_ch0", 64'(ch_data_o[7:0]), 64'h18);
    do_reset();
`endif

    // Basic in-order frame.
    do_start();
    chk("start_busy", 64'(busy_o), 64'd1);
    do_edge(0, 'h11, 0); do_edge(1, 'h22, 0); do_edge(2, 'h33, 0); do_edge(3, 'h44, 0);
    expect_frame("basic");

    // Repeated address overwrites its slot.
    do_start();
    do_edge(1, 'hAA, 0); do_edge(1, 'hBB, 0); do_edge(0, 'h01, 0);
    do_edge(2, 'h02, 0); do_edge(3, 'h03, 0);
    expect_frame("repeat");

    // Edge coinciding with start is not captured; frame then times out.
    add_i = 3'd0; data_i = 'h99; oe_i = 1'b1; fv0 = fv_cnt; to0 = to_cnt;
    start_i = 1'b1; cyc(); start_i = 1'b0; oe_i = 1'b0; cyc();
    for (int k = 0; k < NUM_CH; k++) m_written[k] = 0;
    do_edge(1, 'h5A, 0); do_edge(2, 'h5B, 0); do_edge(3, 'h5C, 0);
    n = 0;
    while (!timeout_o && n < 40) begin cyc(); n++; end
    chk("tmo_pulse", 64'(timeout_o), 64'd1);
    cyc();
    chk("tmo_cycles", 64'(to_run), 64'(TIMEOUT_CYC));
    chk("tmo_data",   64'(ch_data_o), 64'(m_packed()));
    chk("tmo_busy",   64'(busy_o), 64'd0);
    cyc(); cyc();
    chk("tmo_count",  64'(to_cnt - to0), 64'd1);
    chk("tmo_nofv",   64'(fv_cnt - fv0), 64'd0);

    // Out-of-range address: sticky error, shadow untouched, cleared by start.
    do_start();
    do_edge(0, 'hC0, 0); do_edge(1, 'hC1, 0); do_edge(5, 'hEE, 0);
    chk("aerr_set", 64'(addr_err_o), 64'd1);
    do_edge(2, 'hC2, 0); do_edge(3, 'hC3, 0);
    expect_frame("aerr");
    chk("aerr_sticky", 64'(addr_err_o), 64'd1);
    do_start();
    chk("aerr_clr", 64'(addr_err_o), 64'd0);
    do_edge(3, 'h13, 0); do_edge(2, 'h12, 0); do_edge(1, 'h11, 0); do_edge(0, 'h10, 0);
    expect_frame("aerr_next");

    // Reset mid-frame abandons it silently.
    do_start();
    do_edge(0, 'hDE, 0); do_edge(1, 'hAD, 0);
    to0 = to_cnt;
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin m_ch[k] = 0; m_sh[k] = 0; end
    m_primed = 0;
    chk("mrst_data", 64'(ch_data_o), 64'd0);
    chk("mrst_busy", 64'(busy_o), 64'd0);
    do_start();
    do_edge(2, 'h72, 0); do_edge(0, 'h70, 0); do_edge(3, 'h73, 0); do_edge(1, 'h71, 0);
    expect_frame("mrst");
    chk("mrst_noto", 64'(to_cnt - to0), 64'd0);

    // Randomized frames: shuffled order, optional repeat or bad address,
    // stray start pulses during capture and oe activity while idle.
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        oe_i = 1'($urandom); add_i = 3'($urandom); data_i = DATA_W'($urandom);
        cyc();
      end
      oe_i = 1'b0;
      cyc();
      for (int k = 0; k < NUM_CH; k++) ord[k] = k;
      for (int k = NUM_CH - 1; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
      end
      do_start();
      for (int k = 0; k < NUM_CH - 1; k++) do_edge(ord[k], $urandom_range(0, 255), 1'($urandom));
      kind = $urandom_range(0, 2);
      if (kind == 1) do_edge(ord[$urandom_range(0, NUM_CH - 2)], $urandom_range(0, 255), 1'($urandom));
      if (kind == 2) do_edge($urandom_range(NUM_CH, 7), $urandom_range(0, 255), 1'($urandom));
      do_edge(ord[NUM_CH - 1], $urandom_range(0, 255), 1'($urandom));
      expect_frame($sformatf("rnd%0d", f));
      chk($sformatf("rnd%0d_err", f), 64'(addr_err_o), 64'(m_err));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
